// File: rtl/seq_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_ctrl
// Description : Multi-cycle integer multiply / divide sequencer. Owns no
//               adder; drives one external WIDTH-bit sum_sub instance, one
//               add or subtract per cycle. Shift-add unsigned multiply and
//               restoring divide, launched with a start/busy/done handshake.
//               Optional macro MULDIV_SIGNED_EN adds op_signed (signed
//               divide via magnitude conversion and two fix-up cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
`ifdef MULDIV_SIGNED_EN
    input  logic             op_signed,
`endif
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_cout
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_RUN  = 3'd1;
`ifdef MULDIV_SIGNED_EN
    localparam logic [2:0] c_S_FIXQ = 3'd2;
    localparam logic [2:0] c_S_FIXR = 3'd3;
`endif
    localparam logic [2:0] c_S_DONE = 3'd4;

    // Architectural state
    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_acc;       // product high / partial remainder
    logic [WIDTH-1:0]   r_mq;        // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   r_opb;       // multiplicand / divisor
    logic               r_op_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result_lo;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_div_zero;
`ifdef MULDIV_SIGNED_EN
    logic               r_fix_en;    // signed divide: run FIXQ/FIXR
    logic               r_neg_q;     // operand signs differ
    logic               r_neg_r;     // dividend was negative
`endif

    // Next-state / datapath wires
    logic [2:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_sub;
    logic               w_take;
    logic               w_start_ok;
    logic               w_zero_div;
    logic [WIDTH-1:0]   w_a_load;
    logic [WIDTH-1:0]   w_b_load;

    assign w_start_ok = (r_state == c_S_IDLE) && start;
    assign w_zero_div = op_div && (operand_b == '0);

`ifdef MULDIV_SIGNED_EN
    logic w_sdiv;
    assign w_sdiv   = op_div && op_signed;
    // Magnitudes are formed locally so the shared adder stays free.
    assign w_a_load = (w_sdiv && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
    assign w_b_load = (w_sdiv && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;
`else
    assign w_a_load = operand_a;
    assign w_b_load = operand_b;
`endif

    // Next-state, adder drive and datapath update for the current state
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_mq_nxt    = r_mq;
        w_add_a     = '0;
        w_add_b     = '0;
        w_add_sub   = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    if (w_zero_div) begin
                        // Divide by zero bypasses RUN; results land at once.
                        w_state_nxt = c_S_DONE;
                        w_acc_nxt   = operand_a;
                        w_mq_nxt    = '1;
                    end else begin
                        w_state_nxt = c_S_RUN;
                        w_acc_nxt   = '0;
                        w_mq_nxt    = w_a_load;
                    end
                end
            end
            c_S_RUN: begin
                if (r_op_div) begin
                    w_add_sub = 1'b1;
                    w_add_a   = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
                    w_add_b   = r_opb;
                    // A bit shifted out of acc means the partial remainder
                    // exceeds any WIDTH-bit divisor, so the subtract succeeds.
                    w_take    = r_acc[WIDTH-1] | add_cout;
                    w_acc_nxt = w_take ? add_result : w_add_a;
                    w_mq_nxt  = {r_mq[WIDTH-2:0], w_take};
                end else begin
                    w_add_a   = r_acc;
                    w_add_b   = r_mq[0] ? r_opb : '0;
                    {w_acc_nxt, w_mq_nxt} = {add_cout, add_result, r_mq[WIDTH-1:1]};
                end
                if (r_cnt == c_CNT_LAST) begin
`ifdef MULDIV_SIGNED_EN
                    w_state_nxt = r_fix_en ? c_S_FIXQ : c_S_DONE;
`else
                    w_state_nxt = c_S_DONE;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            c_S_FIXQ: begin
                // 0 - quotient
                w_add_sub   = 1'b1;
                w_add_b     = r_mq;
                w_mq_nxt    = r_neg_q ? add_result : r_mq;
                w_state_nxt = c_S_FIXR;
            end
            c_S_FIXR: begin
                // 0 - remainder
                w_add_sub   = 1'b1;
                w_add_b     = r_acc;
                w_acc_nxt   = r_neg_r ? add_result : r_acc;
                w_state_nxt = c_S_DONE;
            end
`endif
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State, datapath, counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_acc       <= '0;
            r_mq        <= '0;
            r_opb       <= '0;
            r_op_div    <= 1'b0;
            r_cnt       <= '0;
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_div_zero  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_fix_en    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_mq    <= w_mq_nxt;
            if (w_start_ok) begin
                r_opb    <= w_b_load;
                r_op_div <= op_div;
                r_cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
                r_fix_en <= w_sdiv;
                r_neg_q  <= w_sdiv && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                r_neg_r  <= w_sdiv && operand_a[WIDTH-1];
`endif
            end else if (r_state == c_S_RUN) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            // Results are captured on entry to DONE so they are valid with done.
            if (w_state_nxt == c_S_DONE && r_state != c_S_DONE) begin
                r_result_lo <= w_mq_nxt;
                r_result_hi <= w_acc_nxt;
                r_div_zero  <= (r_state == c_S_IDLE);
            end
        end
    end

    assign busy      = (r_state != c_S_IDLE) && (r_state != c_S_DONE);
    assign done      = (r_state == c_S_DONE);
    assign result_lo = r_result_lo;
    assign result_hi = r_result_hi;
    assign div_zero  = r_div_zero;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign add_sub   = w_add_sub;

endmodule
`default_nettype wire
